sram_controller: RTL and testbench

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/sram_controller.sv | 134 +++++++++++++
 tb/tb_sram_controller.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
// Bridges a 32-bit pipeline load/store port onto a 16-bit asynchronous SRAM,
// splitting each access into a low and a high half-word phase of WAIT_CYCLES each.
module sram_controller #(
    parameter int BIT_NUMBER  = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [BIT_NUMBER-1:0] address,
    input  logic [BIT_NUMBER-1:0] write_data,
    output logic [BIT_NUMBER-1:0] read_data,
    output logic                  ready,
    output logic [17:0]           sram_addr,
    input  logic [15:0]           sram_dq_in,
    output logic [15:0]           sram_dq_out,
    output logic                  sram_dq_oe,
    output logic                  sram_we_n
);

    typedef enum logic [1:0] {IDLE, ACC_LO, ACC_HI, DONE} state_t;

    localparam int            CW   = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [BIT_NUMBER-1:0]   read_data_q, read_data_d;
    logic [17:0]             sram_addr_q, sram_addr_d;
    logic [15:0]             sram_dq_out_q, sram_dq_out_d;
    logic                    sram_dq_oe_q, sram_dq_oe_d;
    logic                    sram_we_n_q, sram_we_n_d;

    logic [BIT_NUMBER-1:0]   offs;
    logic                    req, is_rd, phase_end;
    logic                    unused_offs;

    // Data memory is mapped at byte 1024 of the pipeline address space.
    assign offs        = address - BIT_NUMBER'(1024);
    assign unused_offs = ^{offs[BIT_NUMBER-1:19], offs[1:0]};
    assign req         = rd_en | wr_en;
    assign is_rd       = rd_en & ~wr_en;
    assign phase_end   = (cnt_q == LAST);

    assign ready = (state_q == DONE) || (state_q == IDLE && !req);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = ACC_LO;
                    cnt_d   = '0;
                end
            end
            ACC_LO: begin
                if (phase_end) begin
                    state_d = ACC_HI;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ACC_HI: begin
                if (phase_end) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // SRAM pins are registered from the next state so they line up with the phase.
    always_comb begin
        sram_addr_d   = 18'd0;
        sram_dq_out_d = 16'd0;
        sram_dq_oe_d  = 1'b0;
        sram_we_n_d   = 1'b1;
        if (state_d == ACC_LO || state_d == ACC_HI) begin
            sram_addr_d = {offs[18:2], (state_d == ACC_HI)};
            if (wr_en) begin
                sram_we_n_d   = 1'b0;
                sram_dq_oe_d  = 1'b1;
                sram_dq_out_d = (state_d == ACC_HI) ? write_data[16 +: 16] : write_data[15:0];
            end
        end
    end

    always_comb begin
        read_data_d = read_data_q;
        if (is_rd && phase_end) begin
            if (state_q == ACC_LO) begin
                read_data_d[15:0] = sram_dq_in;
            end else if (state_q == ACC_HI) begin
                read_data_d[16 +: 16] = sram_dq_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            read_data_q   <= '0;
            sram_addr_q   <= 18'd0;
            sram_dq_out_q <= 16'd0;
            sram_dq_oe_q  <= 1'b0;
            sram_we_n_q   <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            read_data_q   <= read_data_d;
            sram_addr_q   <= sram_addr_d;
            sram_dq_out_q <= sram_dq_out_d;
            sram_dq_oe_q  <= sram_dq_oe_d;
            sram_we_n_q   <= sram_we_n_d;
        end
    end

    assign read_data   = read_data_q;
    assign sram_addr   = sram_addr_q;
    assign sram_dq_out = sram_dq_out_q;
    assign sram_dq_oe  = sram_dq_oe_q;
    assign sram_we_n   = sram_we_n_q;

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller: the driver queues per-cycle expectations,
// a negedge monitor pops and compares them against the pins, backed by an SRAM model.
module tb_sram_controller;

    localparam int BN = 32;
    localparam int WC = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en, rd_en;
    logic [BN-1:0] address, write_data, read_data;
    logic          ready;
    logic [17:0]   sram_addr;
    logic [15:0]   sram_dq_in, sram_dq_out;
    logic          sram_dq_oe, sram_we_n;

    sram_controller #(.BIT_NUMBER(BN), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .address(address), .write_data(write_data), .read_data(read_data),
        .ready(ready), .sram_addr(sram_addr), .sram_dq_in(sram_dq_in),
        .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:262143];
    initial for (int i = 0; i < 262144; i++) mem[i] = 16'd0;
    assign sram_dq_in = mem[sram_addr];
    always @(posedge clk) begin
        if (!sram_we_n && sram_dq_oe) mem[sram_addr] <= sram_dq_out;
    end

    typedef struct {
        logic        rdy;
        logic [17:0] addr;
        logic        we_n;
        logic        oe;
        logic [15:0] dq;
        logic        chk_rd;
        logic [31:0] rd;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            cyc++;
            chk($sformatf("c%0d ready", cyc), {31'd0, ready}, {31'd0, mon_e.rdy});
            chk($sformatf("c%0d sram_addr", cyc), {14'd0, sram_addr}, {14'd0, mon_e.addr});
            chk($sformatf("c%0d we_n", cyc), {31'd0, sram_we_n}, {31'd0, mon_e.we_n});
            chk($sformatf("c%0d dq_oe", cyc), {31'd0, sram_dq_oe}, {31'd0, mon_e.oe});
            chk($sformatf("c%0d dq_out", cyc), {16'd0, sram_dq_out}, {16'd0, mon_e.dq});
            if (mon_e.chk_rd) chk($sformatf("c%0d read_data", cyc), read_data, mon_e.rd);
        end
    end

    task automatic drive(input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input exp_t e);
        rd_en = r; wr_en = w; address = a; write_data = d;
        q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n, input logic [31:0] rd);
        exp_t e;
        e = '{rdy: 1'b1, addr: 18'd0, we_n: 1'b1, oe: 1'b0, dq: 16'd0, chk_rd: 1'b1, rd: rd};
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 32'd0, 32'd0, e);
    endtask

    // One full access: request cycle in IDLE, WC low cycles, WC high cycles, DONE.
    task automatic access(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [17:0] lo, input logic [31:0] rd_done);
        exp_t e;
        e = '{rdy: 1'b0, addr: 18'd0, we_n: 1'b1, oe: 1'b0, dq: 16'd0, chk_rd: 1'b0, rd: 32'd0};
        drive(r, w, a, d, e);
        e = '{rdy: 1'b0, addr: lo, we_n: ~w, oe: w, dq: w ? d[15:0] : 16'd0, chk_rd: 1'b0, rd: 32'd0};
        for (int i = 0; i < WC; i++) drive(r, w, a, d, e);
        e = '{rdy: 1'b0, addr: lo | 18'd1, we_n: ~w, oe: w, dq: w ? d[31:16] : 16'd0, chk_rd: 1'b0, rd: 32'd0};
        for (int i = 0; i < WC; i++) drive(r, w, a, d, e);
        e = '{rdy: 1'b1, addr: 18'd0, we_n: 1'b1, oe: 1'b0, dq: 16'd0, chk_rd: 1'b1, rd: rd_done};
        drive(r, w, a, d, e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst ready", {31'd0, ready}, 32'd1);
        chk("rst we_n", {31'd0, sram_we_n}, 32'd1);
        chk("rst dq_oe", {31'd0, sram_dq_oe}, 32'd0);
        chk("rst sram_addr", {14'd0, sram_addr}, 32'd0);
        chk("rst dq_out", {16'd0, sram_dq_out}, 32'd0);
        chk("rst read_data", read_data, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        idle(10, 32'd0);
        access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 18'd2, 32'd0);
        idle(2, 32'd0);
        access(1'b1, 1'b0, 32'd1028, 32'd0, 18'd2, 32'hDEADBEEF);
        idle(1, 32'hDEADBEEF);
        access(1'b1, 1'b1, 32'd1024, 32'h12345678, 18'd0, 32'hDEADBEEF);
        idle(1, 32'hDEADBEEF);
        access(1'b1, 1'b0, 32'd1024, 32'd0, 18'd0, 32'h12345678);
        access(1'b1, 1'b0, 32'd1028, 32'd0, 18'd2, 32'hDEADBEEF);
        idle(1, 32'hDEADBEEF);
        @(negedge clk); #1;
        chk("mem[2]", {16'd0, mem[2]}, 32'h0000BEEF);
        chk("mem[3]", {16'd0, mem[3]}, 32'h0000DEAD);
        chk("mem[0]", {16'd0, mem[0]}, 32'h00005678);
        chk("mem[1]", {16'd0, mem[1]}, 32'h00001234);

        // Abort a write to 2048 (half-words 512/513) in its first high-half cycle.
        @(posedge clk); #1;
        rd_en = 1'b0; wr_en = 1'b1; address = 32'd2048; write_data = 32'hCAFEF00D;
        repeat (3) @(posedge clk);
        #1;
        chk("pre-abort sram_addr", {14'd0, sram_addr}, 32'd513);
        chk("pre-abort we_n", {31'd0, sram_we_n}, 32'd0);
        #2;
        rst = 1'b0;
        #1;
        chk("abort we_n", {31'd0, sram_we_n}, 32'd1);
        chk("abort dq_oe", {31'd0, sram_dq_oe}, 32'd0);
        chk("abort sram_addr", {14'd0, sram_addr}, 32'd0);
        chk("abort dq_out", {16'd0, sram_dq_out}, 32'd0);
        chk("abort read_data", read_data, 32'd0);
        chk("abort ready w/ req", {31'd0, ready}, 32'd0);
        wr_en = 1'b0;
        #1;
        chk("abort ready no req", {31'd0, ready}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        chk("abort mem[512]", {16'd0, mem[512]}, 32'h0000F00D);
        chk("abort mem[513]", {16'd0, mem[513]}, 32'd0);
        idle(2, 32'd0);
        access(1'b1, 1'b0, 32'd1028, 32'd0, 18'd2, 32'hDEADBEEF);
        idle(1, 32'hDEADBEEF);
        @(negedge clk); #1;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
